// File: rtl/video_stream_checker.sv
// Receive-side monitor for a vs/de/data RGB565 stream: measures each frame's
// active geometry, sums its pixels and flags deviations from the expected size.
module video_stream_checker #(
  parameter int ACTIVE_IW = 640,
  parameter int ACTIVE_IH = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vs,
  input  logic        de,
  input  logic [15:0] data,
  output logic [11:0] meas_width,
  output logic [11:0] meas_height,
  output logic [15:0] checksum,
  output logic        width_err,
  output logic        height_err,
  output logic        stray_de,
  output logic        result_valid,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {WAIT_LOW, IDLE, ACTIVE, REPORT} state_t;

  localparam logic [11:0] EXP_W = 12'(ACTIVE_IW);
  localparam logic [11:0] EXP_H = 12'(ACTIVE_IH);
  localparam logic [11:0] SAT   = 12'hFFF;

  state_t      state;
  logic        vs_d, de_d;
  logic [11:0] run_cnt, line_cnt, width_acc;
  logic [15:0] sum;
  logic        width_err_acc, stray_acc;

  logic        vs_rise, line_end;
  logic [11:0] line_cnt_nxt, width_nxt;
  logic        width_err_nxt;

  assign vs_rise = vs & ~vs_d;

  // A line closes when de drops, or when vs drops while the line is still open.
  assign line_end      = (state == ACTIVE) && de_d && !(de && vs);
  assign line_cnt_nxt  = (line_end && line_cnt != SAT) ? line_cnt + 12'd1 : line_cnt;
  assign width_nxt     = (line_end && line_cnt == 12'd0) ? run_cnt : width_acc;
  assign width_err_nxt = width_err_acc | (line_end && run_cnt != EXP_W);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= WAIT_LOW;
      vs_d          <= 1'b0;
      de_d          <= 1'b0;
      run_cnt       <= '0;
      line_cnt      <= '0;
      width_acc     <= '0;
      sum           <= '0;
      width_err_acc <= 1'b0;
      stray_acc     <= 1'b0;
      meas_width    <= '0;
      meas_height   <= '0;
      checksum      <= '0;
      width_err     <= 1'b0;
      height_err    <= 1'b0;
      stray_de      <= 1'b0;
      result_valid  <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      vs_d         <= vs;
      de_d         <= de;
      result_valid <= 1'b0;

      case (state)
        WAIT_LOW: begin
          // Never measure a frame that was already running when we came up.
          if (!vs) state <= IDLE;
        end

        IDLE, REPORT: begin
          if (vs_rise) begin
            state         <= ACTIVE;
            line_cnt      <= '0;
            width_acc     <= '0;
            width_err_acc <= 1'b0;
            run_cnt       <= de ? 12'd1 : 12'd0;
            sum           <= de ? data : 16'd0;
          end else begin
            state <= IDLE;
            if (de && !vs) stray_acc <= 1'b1;
          end
        end

        ACTIVE: begin
          if (!vs) begin
            // Results are registered here so result_valid is high during REPORT.
            state        <= REPORT;
            meas_width   <= width_nxt;
            meas_height  <= line_cnt_nxt;
            checksum     <= sum;
            width_err    <= width_err_nxt;
            height_err   <= (line_cnt_nxt != EXP_H);
            stray_de     <= stray_acc | de;
            stray_acc    <= 1'b0;
            result_valid <= 1'b1;
            frame_cnt    <= frame_cnt + 16'd1;
          end else begin
            if (de) begin
              sum <= sum + data;
              if (run_cnt != SAT) run_cnt <= run_cnt + 12'd1;
            end
            if (line_end) run_cnt <= '0;
            line_cnt      <= line_cnt_nxt;
            width_acc     <= width_nxt;
            width_err_acc <= width_err_nxt;
          end
        end

        default: state <= WAIT_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_video_stream_checker.sv
// Bench for video_stream_checker: directed frames with hand-computed results,
// then randomized streams compared every cycle against a frame-level model.
module tb_video_stream_checker;

  localparam int IW = 8;
  localparam int IH = 4;

  logic        clk = 1'b0;
  logic        rst, vs, de;
  logic [15:0] data;
  logic [11:0] meas_width, meas_height;
  logic [15:0] checksum, frame_cnt;
  logic        width_err, height_err, stray_de, result_valid;

  video_stream_checker #(.ACTIVE_IW(IW), .ACTIVE_IH(IH)) dut (
    .clk(clk), .rst(rst), .vs(vs), .de(de), .data(data),
    .meas_width(meas_width), .meas_height(meas_height), .checksum(checksum),
    .width_err(width_err), .height_err(height_err), .stray_de(stray_de),
    .result_valid(result_valid), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: remembers the lengths of all lines of the current
  // frame and derives the report from that list when vs drops.
  bit          m_started = 0;
  bit          m_locked, m_in_frame, m_pv, m_pd, m_stray;
  int          m_lines[$];
  int          m_cur;
  logic [15:0] m_acc;
  logic        m_valid, m_werr, m_herr, m_stray_o;
  logic [11:0] m_w, m_h;
  logic [15:0] m_sum, m_cnt;

  always @(posedge clk) begin
    m_started = 1;
    m_valid   = 0;
    if (rst) begin
      m_locked = 0; m_in_frame = 0; m_pv = 0; m_pd = 0; m_stray = 0;
      m_lines.delete(); m_cur = 0; m_acc = 0;
      m_w = 0; m_h = 0; m_sum = 0; m_werr = 0; m_herr = 0; m_stray_o = 0; m_cnt = 0;
    end else begin
      if (!m_locked) begin
        if (!vs) m_locked = 1;
      end else if (!m_in_frame) begin
        if (vs && !m_pv) begin
          m_in_frame = 1;
          m_lines.delete();
          m_cur = de ? 1 : 0;
          m_acc = de ? data : 16'd0;
        end else if (de && !vs) begin
          m_stray = 1;
        end
      end else if (vs) begin
        if (de) begin
          m_cur++;
          m_acc = m_acc + data;
        end else if (m_pd) begin
          m_lines.push_back(m_cur > 4095 ? 4095 : m_cur);
          m_cur = 0;
        end
      end else begin
        if (m_pd) m_lines.push_back(m_cur > 4095 ? 4095 : m_cur);
        m_w    = (m_lines.size() > 0) ? 12'(m_lines[0]) : 12'd0;
        m_h    = (m_lines.size() > 4095) ? 12'd4095 : 12'(m_lines.size());
        m_sum  = m_acc;
        m_werr = 0;
        foreach (m_lines[i]) if (m_lines[i] != IW) m_werr = 1;
        m_herr    = (int'(m_h) != IH);
        m_stray_o = m_stray | de;
        m_stray   = 0;
        m_cnt     = m_cnt + 16'd1;
        m_valid   = 1;
        m_in_frame = 0;
      end
      m_pv = vs;
      m_pd = de;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      check("result_valid", result_valid, m_valid);
      check("meas_width",   meas_width,   m_w);
      check("meas_height",  meas_height,  m_h);
      check("checksum",     checksum,     m_sum);
      check("width_err",    width_err,    m_werr);
      check("height_err",   height_err,   m_herr);
      check("stray_de",     stray_de,     m_stray_o);
      check("frame_cnt",    frame_cnt,    m_cnt);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic cyc(input logic v, input logic d, input logic [15:0] x);
    vs = v; de = d; data = x;
    @(negedge clk);
  endtask

  int pix;

  // One frame: vs front porch, nl lines (line short_idx gets short_len pixels),
  // short horizontal blanks, then the vs fall edge. Returns in the REPORT cycle.
  task automatic frame(input int nl, input int short_idx, input int short_len, input bit rnd);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    for (int l = 0; l < nl; l++) begin
      int len;
      len = (l == short_idx) ? short_len : IW;
      for (int p = 0; p < len; p++) begin
        cyc(1, 1, rnd ? 16'($urandom) : 16'(pix));
        pix++;
      end
      repeat (1 + $urandom_range(2)) cyc(1, 0, 0);
    end
    cyc(0, 0, 0);
  endtask

  task automatic expect_report(input string tag, input int w, input int h, input int sum,
                               input bit werr, input bit herr, input bit stray, input int cnt);
    check({tag, "_valid"},  result_valid, 1);
    check({tag, "_width"},  meas_width,   w);
    check({tag, "_height"}, meas_height,  h);
    check({tag, "_sum"},    checksum,     sum);
    check({tag, "_werr"},   width_err,    werr);
    check({tag, "_herr"},   height_err,   herr);
    check({tag, "_stray"},  stray_de,     stray);
    check({tag, "_cnt"},    frame_cnt,    cnt);
  endtask

  logic cv, cd;

  initial begin
    rst = 1; vs = 1; de = 0; data = 0;
    repeat (3) @(negedge clk);
    check("reset_valid", result_valid, 0);
    check("reset_cnt",   frame_cnt,    0);
    check("reset_sum",   checksum,     0);
    check("reset_width", meas_width,   0);

    // Partial frame already running when reset releases: must be ignored.
    rst = 0;
    for (int i = 0; i < 12; i++) cyc(1, (i % 4) != 0, 16'(i + 100));
    cyc(0, 0, 0);
    check("partial_no_report", result_valid, 0);
    repeat (3) cyc(0, 0, 0);

    // Clean 8x4 frame, data 0..31.
    pix = 0;
    frame(4, -1, 0, 0);
    expect_report("clean", 8, 4, 16'h01F0, 0, 0, 0, 1);
    repeat (3) cyc(0, 0, 0);

    // Line 3 one pixel short: data 0..30.
    pix = 0;
    frame(4, 2, 7, 0);
    expect_report("short", 8, 4, 16'h01D1, 1, 0, 0, 2);
    repeat (3) cyc(0, 0, 0);

    // Five lines, then a stray pixel in vertical blank.
    pix = 0;
    frame(5, -1, 0, 0);
    expect_report("tall", 8, 5, 16'h030C, 0, 1, 0, 3);
    cyc(0, 0, 0);
    cyc(0, 1, 16'h1234);
    repeat (2) cyc(0, 0, 0);
    pix = 0;
    frame(4, -1, 0, 0);
    expect_report("stray", 8, 4, 16'h01F0, 0, 0, 1, 4);
    repeat (3) cyc(0, 0, 0);

    // One-cycle reset in the middle of a frame.
    pix = 0;
    cyc(1, 0, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, 16'(i));
    rst = 1;
    cyc(1, 1, 16'h00AA);
    rst = 0;
    check("midrst_valid",  result_valid, 0);
    check("midrst_cnt",    frame_cnt,    0);
    check("midrst_sum",    checksum,     0);
    check("midrst_width",  meas_width,   0);
    check("midrst_height", meas_height,  0);
    check("midrst_werr",   width_err,    0);
    check("midrst_herr",   height_err,   0);
    check("midrst_stray",  stray_de,     0);
    for (int i = 0; i < 6; i++) cyc(1, 1, 16'(i));
    cyc(0, 0, 0);
    check("midrst_no_report", result_valid, 0);
    repeat (3) cyc(0, 0, 0);
    pix = 0;
    frame(4, -1, 0, 0);
    expect_report("after_rst", 8, 4, 16'h01F0, 0, 0, 0, 1);

    // Randomized phase; the per-cycle compare process carries all checks.
    cv = 0; cd = 0;
    repeat (40) begin
      case ($urandom_range(3))
        0, 1: begin
          frame(3 + $urandom_range(2), ($urandom_range(1) == 1) ? $urandom_range(4) : -1,
                1 + $urandom_range(8), 1);
          repeat ($urandom_range(2)) cyc(0, ($urandom_range(4) == 0), 16'($urandom));
        end
        2: begin
          cyc(1, $urandom_range(1) == 1, 16'($urandom));
          cyc(0, $urandom_range(1) == 1, 16'($urandom));
          cyc(0, 0, 0);
        end
        default: begin
          repeat (80) begin
            if ($urandom_range(11) == 0) cv = ~cv;
            if ($urandom_range(2) == 0) cd = ~cd;
            rst = ($urandom_range(299) == 0);
            cyc(cv, cd, 16'($urandom));
          end
          rst = 0;
        end
      endcase
    end

    repeat (4) cyc(0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
